// File: rtl/uart_ctrl_if.sv
// Host-side 6809-style bus window into the UART controller.
interface uart_ctrl_if;
    logic       cs_b;
    logic       rnw;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq_b;

    modport master (output cs_b, rnw, addr, din, input dout, irq_b);
    modport slave  (input cs_b, rnw, addr, din, output dout, irq_b);
endinterface

// File: rtl/uart_ctrl.sv
// UART host controller: register window, RX pop / TX write sequencing,
// baud tick generator, sticky error flags and active-low interrupt.
module uart_ctrl #(
    parameter logic [7:0] DIV_RESET  = 8'd12,
    parameter logic [2:0] CTRL_RESET = 3'b000
) (
    input  logic       clk,
    input  logic       reset_b,
    uart_ctrl_if.slave bus,
    input  logic [7:0] rx_data,
    input  logic       rx_dor,
    output logic       rx_rd,
    input  logic       rx_frame_error,
    input  logic       rx_overrun,
    input  logic       tx_dir,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic       baud_tick
);
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_BAUD = 2'd3;

    logic       cs_q_r;
    logic       pop_pend_r;
    logic       stat_pend_r;
    logic [2:0] ctrl_r;
    logic [7:0] div_r;
    logic [7:0] cnt_r;
    logic       frame_err_r;
    logic       overrun_r;
    logic       tx_ovf_r;
    logic       irq_b_r;

    logic       start_s;
    logic       end_s;
    logic       wr_start_s;
    logic       clr_s;
    logic       tx_ovf_set_s;
    logic       irq_pending_s;
    logic [7:0] status_s;
    logic [7:0] dout_s;

    assign start_s       = !bus.cs_b && cs_q_r;
    assign end_s         = bus.cs_b && !cs_q_r;
    assign wr_start_s    = start_s && !bus.rnw;
    assign clr_s         = end_s && stat_pend_r;
    assign tx_ovf_set_s  = wr_start_s && (bus.addr == A_DATA) && !tx_dir;
    assign irq_pending_s = (ctrl_r[0] && rx_dor)
                         | (ctrl_r[1] && (frame_err_r || overrun_r || tx_ovf_r))
                         | (ctrl_r[2] && tx_dir);
    assign status_s      = {irq_pending_s, 2'b00, tx_ovf_r, overrun_r, frame_err_r, tx_dir, rx_dor};

    // Read-data mux, live only while a read is being presented.
    always_comb begin
        dout_s = 8'h00;
        if (reset_b && !bus.cs_b && bus.rnw) begin
            case (bus.addr)
                A_DATA:  dout_s = rx_data;
                A_STAT:  dout_s = status_s;
                A_CTRL:  dout_s = {5'b00000, ctrl_r};
                A_BAUD:  dout_s = div_r;
                default: dout_s = 8'h00;
            endcase
        end else begin
            dout_s = 8'h00;
        end
    end

    assign bus.dout  = dout_s;
    assign bus.irq_b = irq_b_r;

    // Access framing, pop/clear bookkeeping, TX write and control register.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cs_q_r      <= 1'b1;
            pop_pend_r  <= 1'b0;
            stat_pend_r <= 1'b0;
            rx_rd       <= 1'b0;
            tx_wr       <= 1'b0;
            tx_data     <= 8'h00;
            ctrl_r      <= CTRL_RESET;
        end else begin
            cs_q_r <= bus.cs_b;
            rx_rd  <= end_s && pop_pend_r;
            if (start_s) begin
                // Decide at access start so the pop/clear ignores later addr/rnw wiggles.
                pop_pend_r  <= bus.rnw && (bus.addr == A_DATA) && rx_dor;
                stat_pend_r <= bus.rnw && (bus.addr == A_STAT);
            end else if (end_s) begin
                pop_pend_r  <= 1'b0;
                stat_pend_r <= 1'b0;
            end else begin
                pop_pend_r  <= pop_pend_r;
                stat_pend_r <= stat_pend_r;
            end
            if (wr_start_s && (bus.addr == A_DATA) && tx_dir) begin
                tx_data <= bus.din;
                tx_wr   <= 1'b1;
            end else begin
                tx_data <= tx_data;
                tx_wr   <= 1'b0;
            end
            if (wr_start_s && (bus.addr == A_CTRL)) begin
                ctrl_r <= bus.din[2:0];
            end else begin
                ctrl_r <= ctrl_r;
            end
        end
    end

    // Sticky error flags; a set wins over a same-cycle status-read clear.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            tx_ovf_r    <= 1'b0;
        end else begin
            frame_err_r <= rx_frame_error || (frame_err_r && !clr_s);
            overrun_r   <= rx_overrun     || (overrun_r   && !clr_s);
            tx_ovf_r    <= tx_ovf_set_s   || (tx_ovf_r    && !clr_s);
        end
    end

    // Baud divisor and down counter; a divisor write restarts the count.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            div_r     <= DIV_RESET;
            cnt_r     <= DIV_RESET;
            baud_tick <= 1'b0;
        end else if (wr_start_s && (bus.addr == A_BAUD)) begin
            div_r     <= bus.din;
            cnt_r     <= bus.din;
            baud_tick <= 1'b0;
        end else if (cnt_r == 8'd0) begin
            cnt_r     <= div_r;
            baud_tick <= 1'b1;
        end else begin
            cnt_r     <= cnt_r - 8'd1;
            baud_tick <= 1'b0;
        end
    end

    // Registered interrupt output.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            irq_b_r <= 1'b1;
        end else begin
            irq_b_r <= !irq_pending_s;
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: stimulus queues per-access expectations,
// a monitor checks dout, tx_wr/tx_data and rx_rd as accesses start and end.
module tb_uart_ctrl;
    logic       clk;
    logic       reset_b;
    logic [7:0] rx_data;
    logic       rx_dor;
    logic       rx_rd;
    logic       rx_frame_error;
    logic       rx_overrun;
    logic       tx_dir;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       baud_tick;

    uart_ctrl_if bus ();

    uart_ctrl #(.DIV_RESET(8'd12), .CTRL_RESET(3'b000)) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .bus            (bus),
        .rx_data        (rx_data),
        .rx_dor         (rx_dor),
        .rx_rd          (rx_rd),
        .rx_frame_error (rx_frame_error),
        .rx_overrun     (rx_overrun),
        .tx_dir         (tx_dir),
        .tx_wr          (tx_wr),
        .tx_data        (tx_data),
        .baud_tick      (baud_tick)
    );

    typedef struct {
        bit         is_read;
        logic [7:0] dout;
        bit         pop;
        bit         wr;
        bit         chk_tx;
        logic [7:0] txd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: samples on the rising edge, away from the falling active edge.
    initial begin
        exp_t cur;
        bit   have_cur;
        bit   prev_cs;
        bit   start_s;
        bit   end_s;
        have_cur = 1'b0;
        prev_cs  = 1'b1;
        forever begin
            @(posedge clk);
            start_s = prev_cs && (bus.cs_b === 1'b0);
            end_s   = !prev_cs && (bus.cs_b === 1'b1);
            if (start_s) begin
                if (exp_q.size() == 0) begin
                    chk("access_queue_empty", 32'd1, 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("tx_wr_at_start", {31'd0, tx_wr}, {31'd0, cur.wr});
                    if (cur.chk_tx) chk("tx_data", {24'd0, tx_data}, {24'd0, cur.txd});
                end
            end else if (tx_wr !== 1'b0) begin
                chk("tx_wr_unexpected", {31'd0, tx_wr}, 32'd0);
            end
            if ((bus.cs_b === 1'b0) && have_cur && cur.is_read)
                chk("rd_dout", {24'd0, bus.dout}, {24'd0, cur.dout});
            if (end_s && have_cur) begin
                chk("rx_rd_at_end", {31'd0, rx_rd}, {31'd0, cur.pop});
                have_cur = 1'b0;
            end else if (rx_rd !== 1'b0) begin
                chk("rx_rd_unexpected", {31'd0, rx_rd}, 32'd0);
            end
            prev_cs = bus.cs_b;
        end
    end

    task automatic access(input bit rd, input logic [1:0] a, input logic [7:0] d,
                          input int ncyc, input exp_t e);
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.cs_b = 1'b0; bus.rnw = rd; bus.addr = a; bus.din = d;
        repeat (ncyc) @(posedge clk);
        #1;
        bus.cs_b = 1'b1; bus.rnw = 1'b1;
    endtask

    task automatic rd_acc(input logic [1:0] a, input logic [7:0] exp_d, input bit pop, input int ncyc);
        exp_t e;
        e = '{is_read: 1'b1, dout: exp_d, pop: pop, wr: 1'b0, chk_tx: 1'b0, txd: 8'h00};
        access(1'b1, a, 8'h00, ncyc, e);
    endtask

    task automatic wr_acc(input logic [1:0] a, input logic [7:0] d, input bit wr,
                          input bit chk_tx, input logic [7:0] txd);
        exp_t e;
        e = '{is_read: 1'b0, dout: 8'h00, pop: 1'b0, wr: wr, chk_tx: chk_tx, txd: txd};
        access(1'b0, a, d, 1, e);
    endtask

    task automatic pulse(input bit fe, input bit ovr);
        @(posedge clk); #1;
        rx_frame_error = fe; rx_overrun = ovr;
        @(posedge clk); #1;
        rx_frame_error = 1'b0; rx_overrun = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Measures the spacing between two consecutive baud ticks.
    task automatic baud_period(input int exp_p, input string nm);
        int n;
        n = 0;
        while (baud_tick !== 1'b1 && n < 300) begin @(posedge clk); n++; end
        if (n >= 300) begin
            chk({nm, "_timeout"}, 32'd1, 32'd0);
        end else begin
            n = 0;
            do begin @(posedge clk); n++; end while (baud_tick !== 1'b1 && n < 300);
            chk(nm, n, exp_p);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_irq_b"},     {31'd0, bus.irq_b}, 32'd1);
        chk({tag, "_tx_data"},   {24'd0, tx_data},   32'd0);
        chk({tag, "_tx_wr"},     {31'd0, tx_wr},     32'd0);
        chk({tag, "_rx_rd"},     {31'd0, rx_rd},     32'd0);
        chk({tag, "_baud_tick"}, {31'd0, baud_tick}, 32'd0);
        chk({tag, "_dout"},      {24'd0, bus.dout},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b = 1'b0;
        bus.cs_b = 1'b1; bus.rnw = 1'b1; bus.addr = 2'd0; bus.din = 8'h00;
        rx_data = 8'h00; rx_dor = 1'b0; rx_frame_error = 1'b0; rx_overrun = 1'b0;
        tx_dir = 1'b1;
        repeat (3) @(posedge clk);
        chk_reset_outputs("in_reset");
        #1 reset_b = 1'b1;
        @(posedge clk);
        chk("post_reset_irq_b", {31'd0, bus.irq_b}, 32'd1);

        rd_acc(2'd1, 8'h02, 1'b0, 1);
        rd_acc(2'd3, 8'h0C, 1'b0, 1);
        rd_acc(2'd2, 8'h00, 1'b0, 1);
        baud_period(13, "baud_reset_period");

        // RX pop: data stable over a 4-cycle access, one pop at the end.
        rx_dor = 1'b1; rx_data = 8'h5A;
        rd_acc(2'd0, 8'h5A, 1'b1, 4);
        @(posedge clk); #1;
        rx_dor = 1'b0; rx_data = 8'h33;
        rd_acc(2'd0, 8'h33, 1'b0, 2);

        // TX write accepted, then refused while the FIFO is full.
        wr_acc(2'd0, 8'h41, 1'b1, 1'b1, 8'h41);
        tx_dir = 1'b0;
        wr_acc(2'd0, 8'h42, 1'b0, 1'b1, 8'h41);
        @(posedge clk);
        chk("tx_data_held", {24'd0, tx_data}, 32'h41);
        rd_acc(2'd1, 8'h10, 1'b0, 1);
        rd_acc(2'd1, 8'h00, 1'b0, 1);
        tx_dir = 1'b1;

        // Overrun with error interrupt enabled.
        wr_acc(2'd2, 8'h02, 1'b0, 1'b0, 8'h00);
        rd_acc(2'd2, 8'h02, 1'b0, 1);
        pulse(1'b0, 1'b1);
        chk("irq_b_overrun", {31'd0, bus.irq_b}, 32'd0);
        rd_acc(2'd1, 8'h8A, 1'b0, 1);
        @(posedge clk);
        chk("irq_b_latency", {31'd0, bus.irq_b}, 32'd0);
        @(posedge clk);
        chk("irq_b_cleared", {31'd0, bus.irq_b}, 32'd1);
        rd_acc(2'd1, 8'h02, 1'b0, 1);

        // Overrun arriving on the clearing cycle survives.
        pulse(1'b0, 1'b1);
        rd_acc(2'd1, 8'h8A, 1'b0, 1);
        rx_overrun = 1'b1;
        @(posedge clk); #1;
        rx_overrun = 1'b0;
        rd_acc(2'd1, 8'h8A, 1'b0, 1);
        rd_acc(2'd1, 8'h02, 1'b0, 1);

        pulse(1'b1, 1'b0);
        rd_acc(2'd1, 8'h86, 1'b0, 1);
        rd_acc(2'd1, 8'h02, 1'b0, 1);

        // TX-space interrupt, then disable it.
        wr_acc(2'd2, 8'h04, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        chk("irq_b_txie", {31'd0, bus.irq_b}, 32'd0);
        wr_acc(2'd2, 8'h00, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        chk("irq_b_disable", {31'd0, bus.irq_b}, 32'd1);

        // Divisor 0: tick every cycle.
        wr_acc(2'd3, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            chk("baud_div0_tick", {31'd0, baud_tick}, 32'd1);
        end
        // Divisor 3: first tick 4 cycles after the write start.
        wr_acc(2'd3, 8'h03, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            chk("baud_div3_quiet", {31'd0, baud_tick}, 32'd0);
        end
        @(posedge clk);
        chk("baud_div3_first", {31'd0, baud_tick}, 32'd1);
        baud_period(4, "baud_div3_period");
        rd_acc(2'd3, 8'h03, 1'b0, 1);

        // Reset in the middle of an addr0 read aborts the pop.
        rx_dor = 1'b1; rx_data = 8'h77;
        begin
            exp_t e;
            e = '{is_read: 1'b1, dout: 8'h77, pop: 1'b0, wr: 1'b0, chk_tx: 1'b0, txd: 8'h00};
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.cs_b = 1'b0; bus.rnw = 1'b1; bus.addr = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b0; bus.cs_b = 1'b1;
        @(posedge clk);
        chk_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b1; rx_dor = 1'b0;
        rd_acc(2'd3, 8'h0C, 1'b0, 1);
        rd_acc(2'd2, 8'h00, 1'b0, 1);
        baud_period(13, "baud_after_reset");

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Host-side controller for the UART. It decodes a 4-register 6809-style bus window and sequences the receiver FIFO pop and the transmitter write. It generates the oversampling baud tick and latches the receiver/transmitter error conditions into sticky status bits. It also drives an active-low interrupt, and sits between the CPU bus and the uartrx/uarttx pair.

Parameters:
DIV_RESET, 8'd12, baud divisor value loaded at reset (tick period = DIV_RESET+1 clk cycles)
CTRL_RESET, 3'b000, interrupt-enable bits loaded at reset

Ports:
clk  input  1  system clock; all state updates on falling edge of clk
reset_b  input  1  asynchronous active-low reset
cs_b  input  1  chip select, active low; one access per low period
rnw  input  1  1 = read, 0 = write (sampled with cs_b)
addr  input  2  register select
din  input  8  host write data
dout  output  8  host read data
irq_b  output  1  interrupt request, active low, registered
rx_data  input  8  head byte of RX FIFO (uartrx host_dout)
rx_dor  input  1  RX data ready (uartrx host_dor)
rx_rd  output  1  one-cycle pop pulse to uartrx host_rd
rx_frame_error  input  1  uartrx frame_error
rx_overrun  input  1  uartrx overrun
tx_dir  input  1  TX FIFO has space
tx_wr  output  1  one-cycle write pulse to transmitter
tx_data  output  8  byte written to transmitter, held until next write
baud_tick  output  1  one-cycle pulse, 16x bit rate enable

Behaviour:
- Reset (async, reset_b low): dout=0, irq_b=1, rx_rd=0, tx_wr=0, tx_data=0, baud_tick=0. Divisor=DIV_RESET, counter=DIV_RESET, ctrl=CTRL_RESET, all sticky flags=0, cs_q=1. Reset mid-access aborts the access: no pop, no write.
- Access framing: cs_q registers cs_b. Start = cs_b low & cs_q high. End = cs_b high & cs_q low. Each low period is exactly one access, whatever its length.
- Register map:
  - addr0 read: rx_data.
  - addr0 write: TX data.
  - addr1 read: status = {irq_pending, 2'b0, tx_ovf, overrun, frame_err, tx_dir, rx_dor}.
  - addr2 read/write: ctrl[2:0] = {txie, errie, rxie}; upper bits read 0.
  - addr3 read/write: baud divisor.
  - Writes to addr1 are ignored.
- dout: combinational mux of the addressed register while cs_b=0 & rnw=1; otherwise 0.
- RX pop: a read of addr0 is latched at access start. rx_rd pulses for 1 cycle on the access-end cycle, so data stays stable for the whole access. No pulse is issued if rx_dor was 0 at start.
- TX write: at the start of a write to addr0:
  - if tx_dir=1: tx_data<=din and tx_wr pulses in the same cycle;
  - else: tx_data is unchanged, no pulse, and tx_ovf is set.
- Sticky flags (frame_err, overrun, tx_ovf):
  - set on any cycle the source is 1;
  - cleared on the end cycle of a status (addr1) read;
  - a set and a clear in the same cycle leaves the flag set.
- Baud: 8-bit down counter.
  - At 0: baud_tick=1 that cycle and the counter reloads the divisor; otherwise it decrements.
  - Divisor 0 gives a tick every cycle.
  - A divisor write reloads the counter at access start; no tick is issued that cycle.
- irq_pending = (rxie & rx_dor) | (errie & (frame_err|overrun|tx_ovf)) | (txie & tx_dir).
  - irq_b <= ~irq_pending, giving 1 cycle of latency.
  - Clearing an enable deasserts irq_b the next cycle.
- Simultaneous events: pop and tx write cannot coincide (different accesses). A sticky set during the clearing status read survives.

Test Plan:
- Reset with DIV_RESET=12 -> irq_b=1, status read=0x02 (tx_dir=1), baud_tick every 13 cycles.
- rx_dor=1, rx_data=0x5A, read addr0 with 4-cycle cs_b low -> dout=0x5A all 4 cycles; exactly one rx_rd pulse, on the cs_b rising cycle.
- Write 0x41 to addr0 with tx_dir=1 -> tx_wr pulses once, tx_data=0x41. Repeat with tx_dir=0 and din=0x42 -> no pulse, tx_data stays 0x41, status bit4=1.
- Pulse rx_overrun 1 cycle, ctrl=0x02 -> status bit3=1, irq_b=0. Status read -> bit3 cleared at access end, irq_b=1 next cycle. Overrun pulse on the clearing cycle -> bit3 remains 1.
- Write addr3=0x00 -> baud_tick continuous. Write 0x03 -> ticks every 4 cycles, first tick 4 cycles after access start.
- Assert reset_b low mid-read of addr0 -> no rx_rd pulse; all outputs at reset values; divisor back to DIV_RESET.
